// File: rtl/fpu_pkg.sv
// Shared types for the FPU special-case stage: operation codes, per-operand
// classification record and the canonical quiet-NaN builder.
package fpu_pkg;

   localparam int QNAN_MAX_W = 128;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10
   } op_e;

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic snan;
      logic sign;
   } fp_class_t;

   // Quiet NaN: sign 0, exponent all-ones, fraction MSB set, rest zero.
   // Built wide and truncated by the caller to its own operand width.
   function automatic logic [QNAN_MAX_W-1:0] make_qnan(input int exp_w, input int man_w);
      logic [QNAN_MAX_W-1:0] q;
      q = '0;
      for (int i = 0; i < QNAN_MAX_W; i++) begin
         if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
            q[i] = 1'b1;
         end
      end
      return q;
   endfunction

endpackage

// File: rtl/fpu_classify.sv
// Classifies one IEEE-style operand into zero / Inf / NaN / sNaN plus sign.
// Subnormals (exponent zero, fraction non-zero) are treated as zero.
module fpu_classify
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] i_x,
   output fp_class_t            o_cls
);

   logic [EXP_W-1:0] w_exp;
   logic [MAN_W-1:0] w_frac;
   logic             w_exp_ones;
   logic             w_frac_zero;

   assign w_exp       = i_x[MAN_W +: EXP_W];
   assign w_frac      = i_x[MAN_W-1:0];
   assign w_exp_ones  = &w_exp;
   assign w_frac_zero = (w_frac == '0);

   always_comb begin
      o_cls      = '0;
      o_cls.sign = i_x[EXP_W+MAN_W];
      o_cls.zero = (w_exp == '0);
      o_cls.inf  = w_exp_ones & w_frac_zero;
      o_cls.nan  = w_exp_ones & ~w_frac_zero;
      o_cls.snan = w_exp_ones & ~w_frac_zero & ~w_frac[MAN_W-1];
   end

endmodule

// File: rtl/fpu_special_case_pipe.sv
// Single-register pipeline stage that resolves IEEE special cases (NaN, Inf,
// zero) for add/sub/mul, with a sticky invalid flag and a special-event counter.
module fpu_special_case_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16,
   localparam int W    = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             special_valid,
   output logic [W-1:0]     special_res,
   output logic [TAG_W-1:0] tag_out,
   output logic             flag_invalid,
   input  logic             flag_clr,
   output logic [CNT_W-1:0] event_cnt
);

   localparam logic [W-1:0]     QNAN     = W'(make_qnan(EXP_W, MAN_W));
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [MAN_W-1:0] FRAC_0   = '0;
   localparam logic [EXP_W-1:0] EXP_0    = '0;

   fp_class_t        w_cls_a;
   fp_class_t        w_cls_b;
   op_e              w_op;
   logic             w_sb_eff;
   logic             w_mul_sign;
   logic             w_special;
   logic             w_invalid;
   logic [W-1:0]     w_res;
   logic             w_accept;
   logic             w_xfer_special;

   logic             r_valid;
   logic             r_special;
   logic [W-1:0]     r_res;
   logic [TAG_W-1:0] r_tag;
   logic             r_flag;
   logic [CNT_W-1:0] r_cnt;

   fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
      .i_x   (a),
      .o_cls (w_cls_a)
   );

   fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
      .i_x   (b),
      .o_cls (w_cls_b)
   );

   // Code 2'b11 falls outside the enum and lands in the add path below.
   assign w_op       = op_e'(op);
   assign w_sb_eff   = w_cls_b.sign ^ (w_op == OP_SUB);
   assign w_mul_sign = w_cls_a.sign ^ w_cls_b.sign;

   always_comb begin
      w_special = 1'b0;
      w_res     = '0;
      w_invalid = w_cls_a.snan | w_cls_b.snan;
      if (w_op == OP_MUL) begin
         if (w_cls_a.nan || w_cls_b.nan) begin
            w_special = 1'b1;
            w_res     = QNAN;
         end else if ((w_cls_a.inf && w_cls_b.zero) || (w_cls_a.zero && w_cls_b.inf)) begin
            w_special = 1'b1;
            w_res     = QNAN;
            w_invalid = 1'b1;
         end else if (w_cls_a.inf || w_cls_b.inf) begin
            w_special = 1'b1;
            w_res     = {w_mul_sign, EXP_ONES, FRAC_0};
         end else if (w_cls_a.zero || w_cls_b.zero) begin
            w_special = 1'b1;
            w_res     = {w_mul_sign, EXP_0, FRAC_0};
         end
      end else begin
         if (w_cls_a.nan || w_cls_b.nan) begin
            w_special = 1'b1;
            w_res     = QNAN;
         end else if (w_cls_a.inf && w_cls_b.inf) begin
            w_special = 1'b1;
            if (w_cls_a.sign != w_sb_eff) begin
               w_res     = QNAN;
               w_invalid = 1'b1;
            end else begin
               w_res = {w_cls_a.sign, EXP_ONES, FRAC_0};
            end
         end else if (w_cls_a.inf) begin
            w_special = 1'b1;
            w_res     = {w_cls_a.sign, EXP_ONES, FRAC_0};
         end else if (w_cls_b.inf) begin
            w_special = 1'b1;
            w_res     = {w_sb_eff, EXP_ONES, FRAC_0};
         end else if (w_cls_a.zero && w_cls_b.zero) begin
            w_special = 1'b1;
            w_res     = {w_cls_a.sign & w_sb_eff, EXP_0, FRAC_0};
         end else if (w_cls_a.zero) begin
            w_special = 1'b1;
            w_res     = {w_sb_eff, b[W-2:0]};
         end else if (w_cls_b.zero) begin
            w_special = 1'b1;
            w_res     = {w_cls_a.sign, a[W-2:0]};
         end
      end
   end

   // in_ready depends only on registered state and out_ready.
   assign in_ready       = !r_valid || out_ready;
   assign w_accept       = in_valid && in_ready;
   assign w_xfer_special = r_valid && out_ready && r_special;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_special <= 1'b0;
         r_res     <= '0;
         r_tag     <= '0;
         r_flag    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (in_ready) begin
            r_valid   <= in_valid;
            r_special <= in_valid && w_special;
            r_res     <= in_valid ? w_res : '0;
            if (in_valid) begin
               r_tag <= tag_in;
            end
         end

         if (w_accept && w_invalid) begin
            r_flag <= 1'b1;
         end else if (flag_clr) begin
            r_flag <= 1'b0;
         end

         // A clear in the same cycle as a counted transfer drops that count.
         if (flag_clr) begin
            r_cnt <= '0;
         end else if (w_xfer_special && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out_valid     = r_valid;
   assign special_valid = r_special;
   assign special_res   = r_res;
   assign tag_out       = r_tag;
   assign flag_invalid  = r_flag;
   assign event_cnt     = r_cnt;

endmodule

// File: tb/tb_fpu_special_case_pipe.sv
// Scoreboard bench for fpu_special_case_pipe: the monitor pushes the expected
// result of every accepted beat and pops/compares on every output transfer.
module tb_fpu_special_case_pipe;

   localparam int W     = 32;
   localparam int TAG_W = 4;
   localparam int CNT_W = 4;

   typedef struct {
      logic             special;
      logic [W-1:0]     res;
      logic [TAG_W-1:0] tag;
   } exp_beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic             special_valid;
   logic [W-1:0]     special_res;
   logic [TAG_W-1:0] tag_out;
   logic             flag_invalid;
   logic             flag_clr;
   logic [CNT_W-1:0] event_cnt;

   logic             exp_special;
   logic [W-1:0]     exp_res;
   logic             exp_inv;
   logic [TAG_W-1:0] tag_ctr = '0;
   logic             mon_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   exp_beat_t sbq[$];

   fpu_special_case_pipe #(
      .EXP_W(8), .MAN_W(23), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .op            (op),
      .a             (a),
      .b             (b),
      .tag_in        (tag_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .special_valid (special_valid),
      .special_res   (special_res),
      .tag_out       (tag_out),
      .flag_invalid  (flag_invalid),
      .flag_clr      (flag_clr),
      .event_cnt     (event_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic sp, input logic [W-1:0] res, input logic inv, input logic clr);
      int k;
      @(negedge clk);
      in_valid    = 1'b1;
      op          = o;
      a           = va;
      b           = vb;
      tag_in      = tag_ctr;
      exp_special = sp;
      exp_res     = res;
      exp_inv     = inv;
      flag_clr    = clr;
      tag_ctr     = tag_ctr + 1'b1;
      k = 0;
      #1;
      while (!in_ready && k < 64) begin
         @(negedge clk);
         flag_clr = 1'b0;
         #1;
         k++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      end
   endtask

   task automatic idle(input logic clr);
      @(negedge clk);
      in_valid = 1'b0;
      flag_clr = clr;
   endtask

   // Monitor: checks outputs against the scoreboard and a flag/counter model.
   initial begin : monitor
      exp_beat_t        e;
      logic             m_flag = 1'b0;
      logic [CNT_W-1:0] m_cnt = '0;
      logic             prev_stall = 1'b0;
      logic             prev_rst = 1'b0;
      logic             xfer_sp;
      logic             s_special;
      logic [W-1:0]     s_res;
      logic [TAG_W-1:0] s_tag;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            chk("flag_invalid", flag_invalid, m_flag);
            chk("event_cnt", event_cnt, m_cnt);
            if (prev_stall && !prev_rst) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_special", special_valid, s_special);
               chk("hold_res", special_res, s_res);
               chk("hold_tag", tag_out, s_tag);
            end
            if (!out_valid) chk("idle_special", special_valid, 0);
            if (!special_valid) chk("nonspecial_res", special_res, 0);
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (rst) begin
               sbq.delete();
               m_flag     = 1'b0;
               m_cnt      = '0;
               prev_stall = 1'b0;
            end else begin
               xfer_sp = 1'b0;
               if (out_valid && out_ready) begin
                  if (sbq.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_beat tag=%0h required=none", tag_out);
                  end else begin
                     e = sbq.pop_front();
                     chk("out_special", special_valid, e.special);
                     chk("out_res", special_res, e.res);
                     chk("out_tag", tag_out, e.tag);
                     xfer_sp = e.special;
                  end
               end
               if (in_valid && in_ready) begin
                  e.special = exp_special;
                  e.res     = exp_special ? exp_res : '0;
                  e.tag     = tag_in;
                  sbq.push_back(e);
               end
               if (in_valid && in_ready && exp_inv) m_flag = 1'b1;
               else if (flag_clr) m_flag = 1'b0;
               if (flag_clr) m_cnt = '0;
               else if (xfer_sp && m_cnt != '1) m_cnt = m_cnt + 1'b1;
               prev_stall = out_valid && !out_ready;
               s_special  = special_valid;
               s_res      = special_res;
               s_tag      = tag_out;
            end
            prev_rst = rst;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time=%0t limit=500000", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
      out_ready = 1'b1; flag_clr = 1'b0;
      exp_special = 1'b0; exp_res = '0; exp_inv = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_special_valid", special_valid, 0);
      chk("rst_special_res", special_res, 0);
      chk("rst_tag_out", tag_out, 0);
      chk("rst_flag", flag_invalid, 0);
      chk("rst_cnt", event_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      mon_en = 1'b1;

      // op, a, b, special, result, invalid, flag_clr
      send(2'b00, 32'h7F800000, 32'hFF800000, 1, 32'h7FC00000, 1, 0);
      send(2'b01, 32'h80000000, 32'h00000000, 1, 32'h80000000, 0, 0);
      send(2'b00, 32'h80000000, 32'h00000000, 1, 32'h00000000, 0, 0);
      send(2'b10, 32'hFF800000, 32'h40000000, 1, 32'hFF800000, 0, 0);
      send(2'b10, 32'h7F800000, 32'h00000000, 1, 32'h7FC00000, 1, 0);
      send(2'b00, 32'h3F800000, 32'h40000000, 0, 32'h00000000, 0, 0);
      send(2'b00, 32'h7FC00000, 32'h3F800000, 1, 32'h7FC00000, 0, 0);
      send(2'b01, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 1, 0);
      send(2'b01, 32'h3F800000, 32'hFF800000, 1, 32'h7F800000, 0, 0);
      send(2'b00, 32'h00000000, 32'hC0000000, 1, 32'hC0000000, 0, 0);
      send(2'b01, 32'h40400000, 32'h00000000, 1, 32'h40400000, 0, 0);
      send(2'b11, 32'h7F800000, 32'h7F800000, 1, 32'h7F800000, 0, 0);
      send(2'b10, 32'h80000000, 32'h3F800000, 1, 32'h80000000, 0, 0);
      send(2'b00, 32'h00000001, 32'h00000002, 1, 32'h00000000, 0, 0);
      send(2'b10, 32'h80400000, 32'h40000000, 1, 32'h80000000, 0, 0);
      send(2'b10, 32'hFF800000, 32'hFF800000, 1, 32'h7F800000, 0, 0);
      send(2'b10, 32'h7F800000, 32'h80000000, 1, 32'h7FC00000, 1, 0);
      send(2'b00, 32'h3F800000, 32'h3F800000, 0, 32'h00000000, 0, 0);
      idle(0);
      repeat (2) @(negedge clk);

      // Clear, then sNaN load with a simultaneous clear: set must win.
      idle(1);
      idle(0);
      send(2'b00, 32'h7F800001, 32'h00000000, 1, 32'h7FC00000, 1, 1);
      idle(0);
      @(negedge clk); #3;
      chk("snan_set_wins", flag_invalid, 1);

      // Counter saturation (4-bit counter, 18 special beats).
      idle(1);
      for (int i = 0; i < 18; i++)
         send(2'b10, 32'h00000000, 32'h00000000, 1, 32'h00000000, 0, 0);
      idle(0);
      repeat (3) @(negedge clk);
      #3;
      chk("cnt_saturate", event_cnt, 15);

      // Back-to-back beats into a 3-cycle output stall.
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            send(2'b10, 32'hFF800000, 32'h40000000, 1, 32'hFF800000, 0, 0);
            send(2'b00, 32'h3F800000, 32'h40000000, 0, 32'h00000000, 0, 0);
            send(2'b01, 32'h00000000, 32'h00000000, 1, 32'h00000000, 0, 0);
            idle(0);
         end
         begin
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(negedge clk);

      // Reset mid-stall with in_valid held high during reset.
      out_ready = 1'b0;
      send(2'b10, 32'h7F800000, 32'h3F800000, 1, 32'h7F800000, 0, 0);
      @(negedge clk);
      chk("stall_before_rst", out_valid, 1);
      rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk); #3;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_special", special_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_cnt", event_cnt, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); #3;
      chk("rst_ignored_in_valid", out_valid, 0);

      send(2'b00, 32'h00000000, 32'h80000000, 1, 32'h00000000, 0, 0);
      idle(0);
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_special_case_pipe.md
FPU_SPECIAL_CASE_PIPE -- requirements
Module: fpu_special_case_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent width.
REQ-002 SHALL have parameter MAN_W, default 23: stored fraction width.
REQ-003 SHALL have parameter TAG_W, default 4: sideband tag width carried with each operation.
REQ-004 SHALL have parameter CNT_W, default 16: special-event counter width.
REQ-005 SHALL define W = 1+EXP_W+MAN_W as the operand width.
REQ-006 SHALL run on one clock; reset is synchronous and active-high.
REQ-007 Ports, in this order:
  - clk  in  1  clock, rising edge.
  - rst  in  1  synchronous active-high reset.
  - in_valid  in  1  operand beat valid.
  - in_ready  out  1  stage can accept a beat.
  - op  in  2  operation: 00 add, 01 sub, 10 mul, 11 reserved (treated as add).
  - a  in  W  operand A {sign,exp,frac}.
  - b  in  W  operand B.
  - tag_in  in  TAG_W  sideband.
  - out_valid  out  1  result beat valid.
  - out_ready  in  1  downstream accepts.
  - special_valid  out  1  beat hit a special case.
  - special_res  out  W  special result; all-zero when special_valid=0.
  - tag_out  out  TAG_W  tag of the output beat.
  - flag_invalid  out  1  sticky IEEE invalid flag.
  - flag_clr  in  1  clears the sticky flag.
  - event_cnt  out  CNT_W  saturating count of special beats.

Function
REQ-008 Classification SHALL be per operand:
  - exp all-ones, frac=0: Inf.
  - exp all-ones, frac!=0: NaN; it is signalling when frac MSB=0.
  - exp=0: zero, with subnormals flushed to zero and sign kept.
REQ-009 For sub, SHALL use sign_b_eff = sign_b XOR 1; otherwise sign_b_eff = sign_b.
REQ-010 Add/sub priority:
  - any NaN: qNaN.
  - Inf with opposite-sign Inf: qNaN, invalid.
  - Inf with same-sign Inf: that Inf.
  - exactly one Inf: that Inf, using its effective sign.
  - zero+zero: -0 when both effective signs are 1, else +0.
  - exactly one zero: the other operand, with its effective sign.
REQ-011 Mul priority, with s = sign_a XOR sign_b:
  - any NaN: qNaN.
  - Inf times zero: qNaN, invalid.
  - any Inf: {s, all-ones, 0}.
  - any zero: {s, 0, 0}.
REQ-012 A beat with no special condition SHALL give special_valid=0 and special_res=0.
REQ-013 The canonical qNaN SHALL be {0, all-ones, 1, zeros}.
REQ-014 Any signalling NaN input SHALL raise invalid for that beat, in addition to the cases in REQ-010 and REQ-011.
REQ-015 The stage SHALL have one register, giving latency 1 cycle from accepted input to out_valid.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), with no combinational path from in_valid to in_ready.
REQ-017 A beat is accepted when in_valid && in_ready, and is loaded at the next edge.
REQ-018 If out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 With in_valid && in_ready and out_ready high on the same cycle, throughput SHALL be one beat per cycle.
REQ-020 When out_valid is low, special_valid SHALL be 0.
REQ-021 flag_invalid SHALL set on the edge that loads a beat with invalid, and stay set until flag_clr.
REQ-022 If flag_clr arrives on the same cycle as a new invalid load, set SHALL win.
REQ-023 event_cnt SHALL increment on each accepted output transfer (out_valid && out_ready && special_valid).
REQ-024 event_cnt SHALL saturate at all-ones and never wrap.
REQ-025 flag_clr SHALL also zero event_cnt; a simultaneous increment is lost.

Reset
REQ-026 While rst=1, out_valid, special_valid, special_res, tag_out, flag_invalid and event_cnt SHALL be 0 at the next edge.
REQ-027 After that edge, in_ready SHALL read 1.
REQ-028 A beat in flight at reset SHALL be discarded.
REQ-029 in_valid SHALL be ignored while rst=1.

Structure
REQ-030 Package fpu_pkg SHALL hold:
  - the op enum: OP_ADD, OP_SUB, OP_MUL.
  - a class struct {zero, inf, nan, snan, sign}.
  - a function building the qNaN from EXP_W and MAN_W.
REQ-031 Classification SHALL sit in one sub-module, fpu_classify, instantiated per operand.
REQ-032 Case logic and the pipeline register SHALL live in this module.

Verification
REQ-033 add, a=0x7F800000, b=0xFF800000 -> next cycle special_valid=1, res=0x7FC00000, flag_invalid=1.
REQ-034 sub, a=0x80000000, b=0x00000000 -> res=0x80000000 (-0); add of the same operands -> 0x00000000.
REQ-035 mul, a=0xFF800000, b=0x40000000 -> res=0xFF800000; mul, a=0x7F800000, b=0x00000000 -> 0x7FC00000 with invalid set.
REQ-036 add, a=0x3F800000, b=0x40000000 -> special_valid=0, res=0, and event_cnt unchanged.
REQ-037 Back-to-back beats with out_ready held low for 3 cycles:
  - outputs and tag_out hold stable.
  - in_ready is 0.
  - no beat is lost or duplicated once out_ready rises.
REQ-038 Reset and flag behaviour:
  - flag_clr on the same cycle as a 0x7F800001 (sNaN) load -> flag_invalid stays 1.
  - event_cnt forced near all-ones saturates.
  - rst mid-stall -> out_valid=0 on the next cycle.
